// File: rtl/ram_writer_if.sv
// ram_writer_if: AXI4-Stream sample input and AXI4 write-channel bundle for ram_writer.
// Ports (signals):
//   S_AXIS_*              stream of samples into the writer
//   M_AXI_aw*             write address channel
//   M_AXI_w*              write data channel
//   M_AXI_b*              write response channel
// Modports:
//   master  ram_writer side (stream sink, AXI master)
//   slave   environment side (stream source, AXI slave / memory)
interface ram_writer_if #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [DATA_WIDTH-1:0]    S_AXIS_tdata;
  logic                     S_AXIS_tvalid;
  logic                     S_AXIS_tready;

  logic [MM_ADDR_WIDTH-1:0] M_AXI_awaddr;
  logic [7:0]               M_AXI_awlen;
  logic [2:0]               M_AXI_awsize;
  logic [1:0]               M_AXI_awburst;
  logic [3:0]               M_AXI_awcache;
  logic                     M_AXI_awvalid;
  logic                     M_AXI_awready;

  logic [DATA_WIDTH-1:0]    M_AXI_wdata;
  logic [DATA_WIDTH/8-1:0]  M_AXI_wstrb;
  logic                     M_AXI_wlast;
  logic                     M_AXI_wvalid;
  logic                     M_AXI_wready;

  logic [1:0]               M_AXI_bresp;
  logic                     M_AXI_bvalid;
  logic                     M_AXI_bready;

  modport master (
    input  S_AXIS_tdata, S_AXIS_tvalid,
    output S_AXIS_tready,
    output M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awcache, M_AXI_awvalid,
    input  M_AXI_awready,
    output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    input  M_AXI_wready,
    input  M_AXI_bresp, M_AXI_bvalid,
    output M_AXI_bready
  );

  modport slave (
    output S_AXIS_tdata, S_AXIS_tvalid,
    input  S_AXIS_tready,
    input  M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awcache, M_AXI_awvalid,
    output M_AXI_awready,
    input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    output M_AXI_wready,
    output M_AXI_bresp, M_AXI_bvalid,
    input  M_AXI_bready
  );
endinterface

// File: rtl/ram_writer.sv
// ram_writer: S2MM stage. Buffers an AXI4-Stream of samples in a FIFO and writes
// them to memory as fixed-length AXI4 INCR bursts, one burst outstanding at a time.
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   enable           allows stream intake and new bursts
//   axi              stream input + AXI4 write master (ram_writer_if.master)
//   SM_write_buffer  base address of the current write buffer
//   SM_log_length    buffer size = 2^SM_log_length words
//   SM_writing       1-cycle pulse per accepted W beat
//   error            sticky, set by any non-OKAY write response
module ram_writer #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 16,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  ram_writer_if.master             axi,
  input  logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
  input  logic [4:0]               SM_log_length,
  output logic                     SM_writing,
  output logic                     error
);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int LOG2_BL    = $clog2(BURST_LEN);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W      = 33;  // holds 2^31 words plus two bursts without overflow

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wptr, r_rptr;
  logic [CNT_W-1:0]         r_count;
  logic                     w_full, w_push, w_pop;

  logic [MM_ADDR_WIDTH-1:0] r_awaddr, r_buf;
  logic [OFF_W-1:0]         r_offset;
  logic [7:0]               r_beat;
  logic                     r_error;

  logic                     w_awvalid, w_wvalid, w_bready, w_launch, w_wlast;
  logic [OFF_W-1:0]         w_off_eff, w_off_inc, w_off_adv, w_size;
  logic [4:0]               w_log;
  logic [MM_ADDR_WIDTH-1:0] w_byte_off;

  // ---------------- sample FIFO ----------------
  assign w_full            = (r_count == CNT_W'(FIFO_DEPTH));
  assign axi.S_AXIS_tready = enable & ~w_full;
  assign w_push            = axi.S_AXIS_tvalid & axi.S_AXIS_tready;
  assign w_pop             = w_wvalid & axi.M_AXI_wready;

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wptr] <= axi.S_AXIS_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- burst FSM ----------------
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_launch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (r_count >= CNT_W'(BURST_LEN))) begin
          w_next   = S_ADDR;
          w_launch = 1'b1;
        end
      end
      S_ADDR: begin
        w_awvalid = 1'b1;
        if (axi.M_AXI_awready) w_next = S_DATA;
      end
      S_DATA: begin
        w_wvalid = 1'b1;
        if (axi.M_AXI_wready && (r_beat == 8'(BURST_LEN - 1))) w_next = S_RESP;
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (axi.M_AXI_bvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wlast = (r_state == S_DATA) && (r_beat == 8'(BURST_LEN - 1));

  // ---------------- address / offset ----------------
  // A changed buffer base restarts the offset for the burst being launched.
  assign w_off_eff  = (SM_write_buffer != r_buf) ? '0 : r_offset;
  assign w_byte_off = MM_ADDR_WIDTH'(w_off_eff << BYTE_SHIFT);
  assign w_log      = (SM_log_length < 5'(LOG2_BL)) ? 5'(LOG2_BL) : SM_log_length;
  assign w_size     = OFF_W'(1) << w_log;
  assign w_off_inc  = r_offset + OFF_W'(BURST_LEN);
  // Wrap when the following burst would no longer fit in the buffer.
  assign w_off_adv  = ((w_off_inc + OFF_W'(BURST_LEN)) > w_size) ? '0 : w_off_inc;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awaddr <= '0;
      r_buf    <= '0;
      r_offset <= '0;
      r_beat   <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_awaddr <= SM_write_buffer + w_byte_off;
        r_buf    <= SM_write_buffer;
        r_offset <= w_off_eff;
        r_beat   <= '0;
      end
      if (w_awvalid && axi.M_AXI_awready) r_offset <= w_off_adv;
      if (w_pop) r_beat <= r_beat + 8'd1;
      if (w_bready && axi.M_AXI_bvalid && (axi.M_AXI_bresp != 2'b00)) r_error <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign axi.M_AXI_awaddr  = r_awaddr;
  assign axi.M_AXI_awlen   = 8'(BURST_LEN - 1);
  assign axi.M_AXI_awsize  = 3'(BYTE_SHIFT);
  assign axi.M_AXI_awburst = 2'b01;
  assign axi.M_AXI_awcache = 4'b0011;
  assign axi.M_AXI_awvalid = w_awvalid;
  assign axi.M_AXI_wdata   = r_mem[r_rptr];
  assign axi.M_AXI_wstrb   = '1;
  assign axi.M_AXI_wlast   = w_wlast;
  assign axi.M_AXI_wvalid  = w_wvalid;
  assign axi.M_AXI_bready  = w_bready;
  assign SM_writing        = w_pop;
  assign error             = r_error;
endmodule

// File: tb/tb_ram_writer.sv
module tb_ram_writer;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] sm_buf = 32'h1000_0000;
  logic [4:0]  sm_log = 5'd6;
  logic        sm_writing, err_o;

  ram_writer_if #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ram_writer #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16), .FIFO_DEPTH(64)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .axi(bus),
    .SM_write_buffer(sm_buf), .SM_log_length(sm_log),
    .SM_writing(sm_writing), .error(err_o)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  bit          exp_err[$];
  int  mon_beat = 0;
  int  wcnt = 0;
  bit  pend_err = 0;
  bit  b_arm = 0;
  int  b_idx = 0;
  int  bad_idx = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endfunction

  // Monitor: compares every handshake against the scoreboard queues.
  always @(negedge aclk) begin
    if (!areset) begin
      if (pend_err) begin
        pend_err = 0;
        if (exp_err.size() == 0) fail("unexpected_b");
        else chk("error_after_b", err_o, exp_err.pop_front());
      end
      if (bus.M_AXI_awvalid && bus.M_AXI_awready) begin
        if (exp_aw.size() == 0) fail("unexpected_aw");
        else chk("awaddr", bus.M_AXI_awaddr, exp_aw.pop_front());
        chk("awlen", bus.M_AXI_awlen, 8'd15);
        chk("aw_attr", {bus.M_AXI_awsize, bus.M_AXI_awburst, bus.M_AXI_awcache}, {3'd2, 2'b01, 4'b0011});
      end
      if (bus.M_AXI_wvalid && bus.M_AXI_wready) begin
        if (exp_w.size() == 0) fail("unexpected_w");
        else chk("wdata", bus.M_AXI_wdata, exp_w.pop_front());
        chk("wlast", bus.M_AXI_wlast, (mon_beat % 16) == 15);
        chk("wstrb", bus.M_AXI_wstrb, 4'hF);
        chk("sm_writing_hs", sm_writing, 1'b1);
        if (bus.M_AXI_wlast) b_arm = 1;
        mon_beat++;
        wcnt++;
      end else if (bus.M_AXI_wvalid) begin
        chk("sm_writing_stall", sm_writing, 1'b0);
      end
      if (bus.M_AXI_bvalid && bus.M_AXI_bready) pend_err = 1;
    end
  end

  // Slave: always-ready AW, programmable W, one B per burst.
  initial begin
    bus.M_AXI_awready = 1'b1;
    bus.M_AXI_wready  = 1'b1;
    bus.M_AXI_bvalid  = 1'b0;
    bus.M_AXI_bresp   = 2'b00;
    forever begin
      @(posedge aclk);
      #1;
      if (areset) begin
        bus.M_AXI_bvalid = 1'b0;
      end else if (bus.M_AXI_bvalid) begin
        bus.M_AXI_bvalid = 1'b0;
      end else if (b_arm) begin
        b_arm = 0;
        bus.M_AXI_bvalid = 1'b1;
        bus.M_AXI_bresp  = (b_idx == bad_idx) ? 2'b10 : 2'b00;
        b_idx++;
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk);
    #1;
    areset = 1'b1;
    bus.S_AXIS_tvalid = 1'b0;
    bus.M_AXI_wready  = 1'b1;
    exp_aw.delete();
    exp_w.delete();
    exp_err.delete();
    b_arm = 0; b_idx = 0; bad_idx = -1; pend_err = 0;
    mon_beat = 0; wcnt = 0;
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_awvalid", bus.M_AXI_awvalid, 1'b0);
    chk("rst_wvalid", bus.M_AXI_wvalid, 1'b0);
    chk("rst_bready", bus.M_AXI_bready, 1'b0);
    chk("rst_sm_writing", sm_writing, 1'b0);
    chk("rst_error", err_o, 1'b0);
    chk("rst_awaddr", bus.M_AXI_awaddr, 32'h0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [31:0] base);
    int t;
    @(posedge aclk);
    #1;
    for (int i = 0; i < n; i++) begin
      bus.S_AXIS_tdata  = base + 32'(i);
      bus.S_AXIS_tvalid = 1'b1;
      exp_w.push_back(base + 32'(i));
      t = 0;
      @(negedge aclk);
      while (!bus.S_AXIS_tready && t < 1000) begin
        @(negedge aclk);
        t++;
      end
      if (!bus.S_AXIS_tready) fail("tready_timeout");
      @(posedge aclk);
      #1;
      bus.S_AXIS_tvalid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0 || exp_err.size() != 0) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 3000) fail(name);
    repeat (4) @(negedge aclk);
  endtask

  task automatic push_err(input int n, input bit v);
    for (int i = 0; i < n; i++) exp_err.push_back(v);
  endtask

  initial begin
    int t;
    bus.S_AXIS_tdata  = '0;
    bus.S_AXIS_tvalid = 1'b0;

    // 1: single burst
    do_reset();
    @(negedge aclk);
    chk("t1_tready_idle", bus.S_AXIS_tready, 1'b1);
    exp_aw.push_back(32'h1000_0000);
    push_err(1, 0);
    send_n(16, 32'h0);
    wait_idle("t1_timeout");
    chk("t1_pulses", 32'(wcnt), 32'd16);

    // 2: continuous stream, offset wrap after 4 bursts
    do_reset();
    exp_aw.push_back(32'h1000_0000); exp_aw.push_back(32'h1000_0040);
    exp_aw.push_back(32'h1000_0080); exp_aw.push_back(32'h1000_00C0);
    exp_aw.push_back(32'h1000_0000);
    push_err(5, 0);
    send_n(80, 32'h100);
    wait_idle("t2_timeout");

    // 3: buffer switch restarts offset
    do_reset();
    exp_aw.push_back(32'h1000_0000); exp_aw.push_back(32'h1000_0040);
    push_err(2, 0);
    send_n(32, 32'h200);
    wait_idle("t3a_timeout");
    sm_buf = 32'h1000_0100;
    exp_aw.push_back(32'h1000_0100); exp_aw.push_back(32'h1000_0140);
    push_err(2, 0);
    send_n(32, 32'h300);
    wait_idle("t3b_timeout");
    sm_buf = 32'h1000_0000;

    // 4: W back-pressure fills the FIFO
    do_reset();
    exp_aw.push_back(32'h1000_0000); exp_aw.push_back(32'h1000_0040);
    exp_aw.push_back(32'h1000_0080); exp_aw.push_back(32'h1000_00C0);
    exp_aw.push_back(32'h1000_0000); exp_aw.push_back(32'h1000_0040);
    push_err(6, 0);
    bus.M_AXI_wready = 1'b0;
    fork
      send_n(96, 32'h400);
      begin
        repeat (100) @(negedge aclk);
        chk("t4_tready_full", bus.S_AXIS_tready, 1'b0);
        chk("t4_wvalid_held", bus.M_AXI_wvalid, 1'b1);
        @(posedge aclk);
        #1;
        bus.M_AXI_wready = 1'b1;
      end
    join
    wait_idle("t4_timeout");

    // 5: SLVERR on burst 2 is sticky
    do_reset();
    bad_idx = 1;
    exp_aw.push_back(32'h1000_0000); exp_aw.push_back(32'h1000_0040);
    exp_aw.push_back(32'h1000_0080);
    exp_err.push_back(0); exp_err.push_back(1); exp_err.push_back(1);
    send_n(48, 32'h500);
    wait_idle("t5_timeout");
    chk("t5_error_sticky", err_o, 1'b1);

    // 6: reset mid-burst abandons burst and flushes FIFO
    do_reset();
    exp_aw.push_back(32'h1000_0000);
    send_n(16, 32'h600);
    t = 0;
    while (wcnt < 4 && t < 500) begin
      @(posedge aclk);
      t++;
    end
    if (wcnt < 4) fail("t6_beat_timeout");
    do_reset();
    exp_aw.push_back(32'h1000_0000);
    push_err(1, 0);
    send_n(16, 32'h700);
    wait_idle("t6_timeout");
    chk("t6_pulses", 32'(wcnt), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
